// File: rtl/axi_ad9152_tx_sequencer.sv
// AD9152 transmit start-up/run-time sequencer: waits for a settled JESD link, optionally aligns to
// an external sync, opens the DMA path, and mutes on underflow or link loss.
module axi_ad9152_tx_sequencer #(
  parameter int SETTLE_CYCLES    = 256,
  parameter int MUTE_HOLD_CYCLES = 16,
  parameter int UNF_CNT_WIDTH    = 16
) (
  input  logic                     dac_clk,
  input  logic                     dac_rst,
  input  logic                     dac_start,
  input  logic                     dac_sync_mode,
  input  logic                     dac_ext_sync,
  input  logic                     tx_ready,
  input  logic                     dac_dunf,
  input  logic                     dac_unf_clr,
  input  logic                     dac_link_drop_clr,
  output logic                     dac_data_en,
  output logic                     dac_mute,
  output logic                     dac_link_ok,
  output logic [2:0]               dac_seq_state,
  output logic [UNF_CNT_WIDTH-1:0] dac_unf_count,
  output logic                     dac_link_drop
);

  localparam int MAX_CYC = (SETTLE_CYCLES > MUTE_HOLD_CYCLES) ? SETTLE_CYCLES : MUTE_HOLD_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0]         SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]         MUTE_LAST   = CNT_W'(MUTE_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]         CNT_ONE     = CNT_W'(1);
  localparam logic [UNF_CNT_WIDTH-1:0] UNF_MAX     = '1;
  localparam logic [UNF_CNT_WIDTH-1:0] UNF_ONE     = UNF_CNT_WIDTH'(1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_LINK = 3'd1,
    SETTLE    = 3'd2,
    ARM       = 3'd3,
    RUN       = 3'd4,
    MUTE      = 3'd5
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             link_up_state;
  logic             unf_event;
  logic             drop_event;

  assign link_up_state = (state == ARM) || (state == RUN) || (state == MUTE);
  assign unf_event     = dac_dunf && ((state == RUN) || (state == MUTE));
  assign drop_event    = dac_start && !tx_ready && link_up_state;

  always_ff @(posedge dac_clk) begin
    if (dac_rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Global exits (start low, link low) take priority over every per-state rule.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (!dac_start) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else if (!tx_ready) begin
      state_nxt = WAIT_LINK;
      cnt_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nxt = WAIT_LINK;
          cnt_nxt   = '0;
        end
        WAIT_LINK: begin
          state_nxt = SETTLE;
          cnt_nxt   = '0;
        end
        SETTLE: begin
          if (cnt == SETTLE_LAST) begin
            state_nxt = ARM;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
        ARM: begin
          if (!dac_sync_mode || dac_ext_sync) begin
            state_nxt = RUN;
          end
        end
        RUN: begin
          if (dac_dunf) begin
            state_nxt = MUTE;
            cnt_nxt   = '0;
          end
        end
        MUTE: begin
          // A fresh underflow restarts the full hold window.
          if (dac_dunf) begin
            cnt_nxt = '0;
          end else if (cnt == MUTE_LAST) begin
            state_nxt = RUN;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Clear and a coincident event yield one, so no underflow goes unreported.
  always_ff @(posedge dac_clk) begin
    if (dac_rst) begin
      dac_unf_count <= '0;
    end else if (dac_unf_clr) begin
      dac_unf_count <= unf_event ? UNF_ONE : '0;
    end else if (unf_event && (dac_unf_count != UNF_MAX)) begin
      dac_unf_count <= dac_unf_count + UNF_ONE;
    end
  end

  always_ff @(posedge dac_clk) begin
    if (dac_rst) begin
      dac_link_drop <= 1'b0;
    end else if (drop_event) begin
      dac_link_drop <= 1'b1;
    end else if (dac_link_drop_clr) begin
      dac_link_drop <= 1'b0;
    end
  end

  assign dac_seq_state = state;
  assign dac_data_en   = (state == RUN) || (state == MUTE);
  assign dac_mute      = (state != RUN);
  assign dac_link_ok   = link_up_state;

endmodule

// File: tb/tb_axi_ad9152_tx_sequencer.sv
// Self-checking bench for axi_ad9152_tx_sequencer: vector table, directed corner sequences and
// randomized traffic compared against a cycle-level behavioural model.
module tb_axi_ad9152_tx_sequencer;

  localparam int SETTLE = 4;
  localparam int HOLD   = 16;
  localparam int UW     = 3;
  localparam int UNF_MAX = (1 << UW) - 1;

  localparam int S_IDLE = 0, S_WAIT = 1, S_SETTLE = 2, S_ARM = 3, S_RUN = 4, S_MUTE = 5;

  logic          dac_clk = 1'b0;
  logic          dac_rst = 1'b0;
  logic          dac_start = 1'b0;
  logic          dac_sync_mode = 1'b0;
  logic          dac_ext_sync = 1'b0;
  logic          tx_ready = 1'b0;
  logic          dac_dunf = 1'b0;
  logic          dac_unf_clr = 1'b0;
  logic          dac_link_drop_clr = 1'b0;
  logic          dac_data_en;
  logic          dac_mute;
  logic          dac_link_ok;
  logic [2:0]    dac_seq_state;
  logic [UW-1:0] dac_unf_count;
  logic          dac_link_drop;

  int checks = 0;
  int errors = 0;

  // Model state: phase, cycles spent so far in the current settle/mute window, counters.
  int m_state = 0;
  int m_settle_seen = 0;
  int m_quiet = 0;
  int m_unf = 0;
  int m_drop = 0;

  axi_ad9152_tx_sequencer #(
    .SETTLE_CYCLES(SETTLE),
    .MUTE_HOLD_CYCLES(HOLD),
    .UNF_CNT_WIDTH(UW)
  ) dut (
    .dac_clk(dac_clk),
    .dac_rst(dac_rst),
    .dac_start(dac_start),
    .dac_sync_mode(dac_sync_mode),
    .dac_ext_sync(dac_ext_sync),
    .tx_ready(tx_ready),
    .dac_dunf(dac_dunf),
    .dac_unf_clr(dac_unf_clr),
    .dac_link_drop_clr(dac_link_drop_clr),
    .dac_data_en(dac_data_en),
    .dac_mute(dac_mute),
    .dac_link_ok(dac_link_ok),
    .dac_seq_state(dac_seq_state),
    .dac_unf_count(dac_unf_count),
    .dac_link_drop(dac_link_drop)
  );

  always #5 dac_clk = ~dac_clk;

  typedef struct {
    logic       rst, start, sync_mode, ext_sync, ready, dunf, unf_clr, drop_clr;
    logic [2:0] exp_state;
    logic       exp_en, exp_mute, exp_ok, exp_drop;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, input logic start, input logic ready,
                              input logic [2:0] st, input logic drop);
    vec_t v;
    v.rst = rst; v.start = start; v.sync_mode = 1'b0; v.ext_sync = 1'b0;
    v.ready = ready; v.dunf = 1'b0; v.unf_clr = 1'b0; v.drop_clr = 1'b0;
    v.exp_state = st;
    v.exp_en = (st == 3'd4) || (st == 3'd5);
    v.exp_mute = (st != 3'd4);
    v.exp_ok = (st >= 3'd3) && (st <= 3'd5);
    v.exp_drop = drop;
    return v;
  endfunction

  // One clock of the specified behaviour, using the inputs the DUT sampled on this edge.
  function automatic void model_step();
    bit running = (m_state == S_RUN) || (m_state == S_MUTE);
    bit linked  = running || (m_state == S_ARM);
    bit ev      = dac_dunf && running;
    if (dac_rst) begin
      m_state = S_IDLE; m_settle_seen = 0; m_quiet = 0; m_unf = 0; m_drop = 0;
      return;
    end
    if (dac_unf_clr) m_unf = ev ? 1 : 0;
    else if (ev) m_unf = (m_unf + 1 > UNF_MAX) ? UNF_MAX : m_unf + 1;
    if (dac_start && !tx_ready && linked) m_drop = 1;
    else if (dac_link_drop_clr) m_drop = 0;
    if (!dac_start) m_state = S_IDLE;
    else if (!tx_ready) m_state = S_WAIT;
    else if (m_state == S_IDLE) m_state = S_WAIT;
    else if (m_state == S_WAIT) begin
      m_state = S_SETTLE; m_settle_seen = 1;
    end else if (m_state == S_SETTLE) begin
      if (m_settle_seen >= SETTLE) m_state = S_ARM;
      else m_settle_seen++;
    end else if (m_state == S_ARM) begin
      if (!dac_sync_mode || dac_ext_sync) m_state = S_RUN;
    end else if (m_state == S_RUN) begin
      if (dac_dunf) begin
        m_state = S_MUTE; m_quiet = 1;
      end
    end else if (m_state == S_MUTE) begin
      if (dac_dunf) m_quiet = 1;
      else if (m_quiet >= HOLD) m_state = S_RUN;
      else m_quiet++;
    end else m_state = S_IDLE;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic tick();
    logic [5:0] exp_flags;
    @(posedge dac_clk);
    model_step();
    #1;
    exp_flags = {3'(m_state), (m_state == S_RUN) || (m_state == S_MUTE), m_state != S_RUN,
                 (m_state >= S_ARM) && (m_state <= S_MUTE)};
    checkOutput("model_state_flags", {26'd0, dac_seq_state, dac_data_en, dac_mute, dac_link_ok},
                {26'd0, exp_flags});
    checkOutput("model_unf_count", 32'(dac_unf_count), 32'(m_unf));
    checkOutput("model_link_drop", 32'(dac_link_drop), 32'(m_drop));
  endtask

  task automatic applyStimulus(input vec_t v);
    dac_rst = v.rst; dac_start = v.start; dac_sync_mode = v.sync_mode; dac_ext_sync = v.ext_sync;
    tx_ready = v.ready; dac_dunf = v.dunf; dac_unf_clr = v.unf_clr; dac_link_drop_clr = v.drop_clr;
    tick();
  endtask

  task automatic wait_state(input int target, input int bound, input string name);
    int n = 0;
    while ((int'(dac_seq_state) != target) && (n < bound)) begin
      tick();
      n++;
    end
    checkOutput(name, 32'(dac_seq_state), 32'(target));
  endtask

  task automatic count_mute(output int n);
    n = 0;
    for (int i = 0; i < 100 && dac_seq_state == 3'd5; i++) begin
      n++;
      tick();
    end
  endtask

  initial begin
    int n;
    // Start-up with SETTLE=4 in free-run mode, then an aborted settle that restarts the count.
    vecs.push_back(mk(1, 0, 0, 3'd0, 0));
    vecs.push_back(mk(0, 1, 1, 3'd1, 0));
    vecs.push_back(mk(0, 1, 1, 3'd2, 0));
    vecs.push_back(mk(0, 1, 1, 3'd2, 0));
    vecs.push_back(mk(0, 1, 1, 3'd2, 0));
    vecs.push_back(mk(0, 1, 1, 3'd2, 0));
    vecs.push_back(mk(0, 1, 1, 3'd3, 0));
    vecs.push_back(mk(0, 1, 1, 3'd4, 0));
    vecs.push_back(mk(0, 1, 1, 3'd4, 0));
    vecs.push_back(mk(0, 0, 1, 3'd0, 0));
    vecs.push_back(mk(0, 1, 1, 3'd1, 0));
    vecs.push_back(mk(0, 1, 1, 3'd2, 0));
    vecs.push_back(mk(0, 1, 1, 3'd2, 0));
    vecs.push_back(mk(0, 1, 1, 3'd2, 0));
    vecs.push_back(mk(0, 1, 0, 3'd1, 0));
    vecs.push_back(mk(0, 1, 1, 3'd2, 0));
    vecs.push_back(mk(0, 1, 1, 3'd2, 0));
    vecs.push_back(mk(0, 1, 1, 3'd2, 0));
    vecs.push_back(mk(0, 1, 1, 3'd2, 0));
    vecs.push_back(mk(0, 1, 1, 3'd3, 0));
    vecs.push_back(mk(0, 1, 1, 3'd4, 0));

    @(negedge dac_clk);
    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d_state", i), 32'(dac_seq_state), 32'(vecs[i].exp_state));
      checkOutput($sformatf("vec%0d_flags", i), {29'd0, dac_data_en, dac_mute, dac_link_ok},
                  {29'd0, vecs[i].exp_en, vecs[i].exp_mute, vecs[i].exp_ok});
      checkOutput($sformatf("vec%0d_drop", i), 32'(dac_link_drop), 32'(vecs[i].exp_drop));
    end

    // External sync: a pulse during SETTLE is ignored, a pulse in ARM starts RUN.
    dac_start = 1'b0; tick();
    dac_start = 1'b1; dac_sync_mode = 1'b1; tick(); tick();
    dac_ext_sync = 1'b1; tick(); dac_ext_sync = 1'b0;
    checkOutput("sync_ignored_in_settle", 32'(dac_seq_state), 32'(S_SETTLE));
    wait_state(S_ARM, 10, "sync_reach_arm");
    for (int i = 0; i < 3; i++) tick();
    checkOutput("sync_hold_arm", 32'(dac_seq_state), 32'(S_ARM));
    dac_ext_sync = 1'b1; tick(); dac_ext_sync = 1'b0;
    checkOutput("sync_arm_to_run", 32'(dac_seq_state), 32'(S_RUN));

    // Underflow mute: plain 16-cycle hold, then a hold restarted at mute cycle 10.
    dac_dunf = 1'b1; tick(); dac_dunf = 1'b0;
    count_mute(n);
    checkOutput("mute_len_plain", 32'(n), 32'(HOLD));
    checkOutput("unf_after_one", 32'(dac_unf_count), 32'd1);
    checkOutput("run_after_mute", 32'(dac_seq_state), 32'(S_RUN));
    dac_dunf = 1'b1; tick(); dac_dunf = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    dac_dunf = 1'b1; tick(); dac_dunf = 1'b0;
    count_mute(n);
    checkOutput("mute_len_extended", 32'(n + 10), 32'(10 + HOLD));
    checkOutput("unf_after_three", 32'(dac_unf_count), 32'd3);

    // Counter clear, saturation at 7, and clear coinciding with an event.
    dac_unf_clr = 1'b1; tick(); dac_unf_clr = 1'b0;
    checkOutput("unf_cleared", 32'(dac_unf_count), 32'd0);
    dac_dunf = 1'b1;
    for (int i = 0; i < 9; i++) tick();
    checkOutput("unf_saturated", 32'(dac_unf_count), 32'(UNF_MAX));
    dac_unf_clr = 1'b1; tick(); dac_unf_clr = 1'b0; dac_dunf = 1'b0;
    checkOutput("unf_clear_with_event", 32'(dac_unf_count), 32'd1);
    wait_state(S_RUN, 40, "unf_back_to_run");

    // Link loss while running, clear colliding with a second drop, then retention through IDLE.
    dac_sync_mode = 1'b0;
    tx_ready = 1'b0; tick();
    checkOutput("drop_state_wait", 32'(dac_seq_state), 32'(S_WAIT));
    checkOutput("drop_set", 32'(dac_link_drop), 32'd1);
    tx_ready = 1'b1;
    wait_state(S_RUN, 20, "drop_back_to_run");
    tx_ready = 1'b0; dac_link_drop_clr = 1'b1; tick(); dac_link_drop_clr = 1'b0;
    checkOutput("drop_set_beats_clear", 32'(dac_link_drop), 32'd1);
    dac_start = 1'b0; tick();
    checkOutput("drop_kept_in_idle", 32'(dac_link_drop), 32'd1);
    checkOutput("idle_after_stop", 32'(dac_seq_state), 32'(S_IDLE));
    dac_link_drop_clr = 1'b1; tick(); dac_link_drop_clr = 1'b0;
    checkOutput("drop_cleared", 32'(dac_link_drop), 32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      dac_rst = ($urandom_range(0, 199) == 0);
      dac_start = ($urandom_range(0, 49) != 0);
      tx_ready = ($urandom_range(0, 29) != 0);
      if ($urandom_range(0, 99) == 0) dac_sync_mode = ~dac_sync_mode;
      dac_ext_sync = ($urandom_range(0, 7) == 0);
      dac_dunf = ($urandom_range(0, 9) == 0);
      dac_unf_clr = ($urandom_range(0, 63) == 0);
      dac_link_drop_clr = ($urandom_range(0, 31) == 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
